// File: rtl/exponent_add_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : exp_seq_pkg
// Brief  : State encoding and exponent constants for exponent_add_sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package exp_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ADD  = 3'd1;
    localparam state_t ST_BIAS = 3'd2;
    localparam state_t ST_INC  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic [7:0] BIAS_NEG = 8'h81;
    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [7:0] EXP_ZERO = 8'h00;

endpackage : exp_seq_pkg
`default_nettype wire

// File: rtl/exponent_add_sequencer_rca.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : Ripple_Carry_Adder_8bit
// Brief  : 8-bit ripple-carry adder, the single shared adder of the sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module Ripple_Carry_Adder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_c;

    assign w_c[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[8];

endmodule : Ripple_Carry_Adder_8bit
`default_nettype wire

// File: rtl/exponent_add_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : exponent_add_sequencer
// Brief  : Computes ea + eb - 127 (+1 on normalisation) over several cycles
//          on one shared adder, saturating to 0xFF / flushing to 0x00.
//          Macro EXP_SEQ_NORM_INC_EN enables the INC step (norm_inc honoured).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module exponent_add_sequencer
    import exp_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] exp_a,
    input  logic [7:0] exp_b,
    input  logic       norm_inc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] exp_out,
    output logic       overflow,
    output logic       underflow
);

    state_t     r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [8:0] r_acc;
    logic [7:0] r_exp;
    logic       r_ovf;
    logic       r_unf;

    logic [7:0] w_op_a;
    logic [7:0] w_op_b;
    logic [7:0] w_sum;
    logic       w_cout;
    logic [1:0] w_bias_hi;
    logic [9:0] w_e_bias;
    logic [9:0] w_e_fin;
    logic       w_to_done;
    logic       w_go_inc;

`ifdef EXP_SEQ_NORM_INC_EN
    logic       r_inc;
    logic [9:0] r_e;
    logic [9:0] w_e_inc;
`else
    logic       w_unused_norm;
    assign w_unused_norm = norm_inc;
`endif

    always_comb begin
        w_op_a = r_a;
        w_op_b = r_b;
        case (r_state)
            ST_BIAS: begin
                w_op_a = r_acc[7:0];
                w_op_b = BIAS_NEG;
            end
`ifdef EXP_SEQ_NORM_INC_EN
            ST_INC: begin
                w_op_a = r_e[7:0];
                w_op_b = 8'h01;
            end
`endif
            default: ;
        endcase
    end

    Ripple_Carry_Adder_8bit u_adder (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // (acc[8] + cout) - 1 gives the signed upper bits of acc - 127
    assign w_bias_hi = {1'b0, r_acc[8]} + {1'b0, w_cout} - 2'd1;
    assign w_e_bias  = {w_bias_hi, w_sum};

`ifdef EXP_SEQ_NORM_INC_EN
    assign w_e_inc   = {r_e[9:8] + {1'b0, w_cout}, w_sum};
    assign w_e_fin   = (r_state == ST_INC) ? w_e_inc : w_e_bias;
    assign w_go_inc  = r_inc;
    assign w_to_done = ((r_state == ST_BIAS) && !r_inc) || (r_state == ST_INC);
`else
    assign w_e_fin   = w_e_bias;
    assign w_go_inc  = 1'b0;
    assign w_to_done = (r_state == ST_BIAS);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 9'h000;
            r_exp   <= EXP_ZERO;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
`ifdef EXP_SEQ_NORM_INC_EN
            r_inc   <= 1'b0;
            r_e     <= 10'h000;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= exp_a;
                        r_b     <= exp_b;
`ifdef EXP_SEQ_NORM_INC_EN
                        r_inc   <= norm_inc;
`endif
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_acc   <= {w_cout, w_sum};
                    r_state <= ST_BIAS;
                end
                ST_BIAS: begin
`ifdef EXP_SEQ_NORM_INC_EN
                    r_e     <= w_e_bias;
`endif
                    r_state <= w_go_inc ? ST_INC : ST_DONE;
                end
                ST_INC:  r_state <= ST_DONE;
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_to_done) begin
                if ($signed(w_e_fin) >= $signed(10'sd255)) begin
                    r_exp <= EXP_MAX;
                    r_ovf <= 1'b1;
                    r_unf <= 1'b0;
                end else if ($signed(w_e_fin) <= $signed(10'sd0)) begin
                    r_exp <= EXP_ZERO;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b1;
                end else begin
                    r_exp <= w_e_fin[7:0];
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign exp_out   = r_exp;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule : exponent_add_sequencer
`default_nettype wire

// File: tb/tb_exponent_add_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_exponent_add_sequencer
// Brief  : Directed plus random self-checking bench for exponent_add_sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_exponent_add_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;
    logic       norm_inc = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] exp_out;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    exponent_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .norm_inc  (norm_inc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

`ifdef EXP_SEQ_NORM_INC_EN
    localparam bit INC_EN = 1'b1;
`else
    localparam bit INC_EN = 1'b0;
`endif

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer exponent arithmetic with saturation.
    task automatic model(input int a, input int b, input bit inc,
                         output int e_out, output int ovf, output int unf, output int lat);
        int e;
        e = a + b - 127 + ((INC_EN && inc) ? 1 : 0);
        lat = (INC_EN && inc) ? 4 : 3;
        ovf = (e >= 255) ? 1 : 0;
        unf = (e <= 0) ? 1 : 0;
        e_out = ovf ? 255 : (unf ? 0 : e);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input bit inc, input int hold);
        int e_exp, ovf_exp, unf_exp, lat_exp, lat, guard;
        model(a, b, inc, e_exp, ovf_exp, unf_exp, lat_exp);
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        exp_a = a; exp_b = b; norm_inc = inc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_a = $urandom; exp_b = $urandom; norm_inc = $urandom;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        check("latency", lat, lat_exp);
        check("exp_out", exp_out, e_exp);
        check("overflow", overflow, ovf_exp);
        check("underflow", underflow, unf_exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = $urandom_range(0, 1);
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_exp_out", exp_out, e_exp);
            check("hold_flags", {overflow, underflow}, {ovf_exp[0], unf_exp[0]});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("done_out_valid_clear", out_valid, 0);
        check("done_in_ready", in_ready, 1);
    endtask

    initial begin
        int a, b;
        bit inc;
        int guard;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_exp_out", exp_out, 0);
        check("rst_flags", {overflow, underflow}, 0);
        check("rst_in_ready", in_ready, 1);

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_out_ready_in_ready", in_ready, 1);
        check("idle_out_ready_out_valid", out_valid, 0);

        txn(8'h80, 8'h7F, 1'b0, 0);
        txn(8'h7F, 8'h7F, 1'b1, 0);
        txn(8'hFE, 8'hFE, 1'b0, 0);
        txn(8'hFE, 8'h80, 1'b0, 0);
        txn(8'h01, 8'h01, 1'b0, 0);
        txn(8'h3F, 8'h40, 1'b0, 0);
        txn(8'h3F, 8'h40, 1'b1, 0);
        txn(8'hFE, 8'h7F, 1'b1, 0);
        txn(8'hC0, 8'h3E, 1'b1, 0);
        txn(8'h90, 8'h85, 1'b1, 5);

        // Reset during BIAS drops the transaction
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        exp_a = 8'hA0; exp_b = 8'h90; norm_inc = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_exp_out", exp_out, 0);
        check("midrst_flags", {overflow, underflow}, 0);
        check("midrst_in_ready", in_ready, 1);
        txn(8'h85, 8'h70, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            a   = $urandom_range(1, 254);
            b   = $urandom_range(1, 254);
            inc = $urandom_range(0, 1);
            txn(a[7:0], b[7:0], inc, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_exponent_add_sequencer
`default_nettype wire
